// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(2^m) types, defaults and reference helpers for the runtime table generator
package gf_pkg;

    localparam int          SYMB_WIDTH = 8;
    localparam int          SYMB_NUM   = 1 << SYMB_WIDTH;
    localparam int unsigned POLY       = 32'h1D;

    typedef enum logic [1:0] {EMPTY, BUILD, READY} gf_tbl_state_e;
    typedef enum logic       {LK_ALOG, LK_LOG}      gf_lk_sel_e;

    // Multiply an element by alpha: shift and reduce by the polynomial (x^m term implicit).
    function automatic int unsigned gf_mul_x(input int unsigned a, input int unsigned poly, input int m);
        int unsigned mask;
        int unsigned sh;
        mask = (32'd1 << m) - 32'd1;
        sh   = (a << 1) & mask;
        if (((a >> (m - 1)) & 32'd1) != 32'd0)
            sh = sh ^ (poly & mask);
        return sh;
    endfunction

    function automatic int unsigned gf_alpha_pow(input int unsigned i, input int unsigned poly, input int m);
        int unsigned v;
        v = 32'd1;
        for (int unsigned k = 0; k < i; k++)
            v = gf_mul_x(v, poly, m);
        return v;
    endfunction

endpackage

// File: rtl/gf_table_gen_if.sv
// rtl/gf_table_gen_if.sv - configuration and lookup bus between a table consumer and gf_table_gen
interface gf_table_gen_if #(
    parameter int SYMB_WIDTH = 8
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [SYMB_WIDTH-1:0] cfg_poly;
    logic                  tbl_ready;
    logic                  done;
    logic                  prim_err;
    logic                  lk_valid;
    logic                  lk_sel;
    logic [SYMB_WIDTH-1:0] lk_addr;
    logic                  lk_rvalid;
    logic [SYMB_WIDTH-1:0] lk_rdata;

    modport master (
        output cfg_valid, cfg_poly, lk_valid, lk_sel, lk_addr,
        input  cfg_ready, tbl_ready, done, prim_err, lk_rvalid, lk_rdata
    );

    modport slave (
        input  cfg_valid, cfg_poly, lk_valid, lk_sel, lk_addr,
        output cfg_ready, tbl_ready, done, prim_err, lk_rvalid, lk_rdata
    );
endinterface

// File: rtl/gf_table_ram.sv
// rtl/gf_table_ram.sv - simple dual-port table RAM, one write port and one registered read port
module gf_table_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [WIDTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Array has no reset so it maps onto block RAM; contents survive reset as don't-care.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/gf_table_gen.sv
// rtl/gf_table_gen.sv - runtime GF(2^m) antilog/log table builder with 1-cycle lookups; optional GF_PRIM_CHECK_EN
module gf_table_gen #(
    parameter int SYMB_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    gf_table_gen_if.slave  bus
);
    import gf_pkg::*;

    localparam int                    DEPTH = 1 << SYMB_WIDTH;
    localparam logic [SYMB_WIDTH-1:0] ONE   = SYMB_WIDTH'(1);
    localparam logic [SYMB_WIDTH-1:0] LAST  = SYMB_WIDTH'(DEPTH - 1);

    gf_tbl_state_e         state;
    logic [SYMB_WIDTH-1:0] poly;
    logic [SYMB_WIDTH-1:0] cur;
    logic [SYMB_WIDTH-1:0] idx;
    logic                  cfg_ready_q;
    logic                  tbl_ready_q;
    logic                  done_q;
    logic                  prim_err_q;
    logic                  lk_rvalid_q;
    gf_lk_sel_e            sel_q;

    logic                  accept;
    logic                  building;
    logic                  last;
    logic                  abort;
    logic                  rd_en;
    logic [SYMB_WIDTH-1:0] next_cur;
    logic [SYMB_WIDTH-1:0] alpha_wdata;
    logic [SYMB_WIDTH-1:0] log_waddr;
    logic [SYMB_WIDTH-1:0] log_wdata;
    logic [SYMB_WIDTH-1:0] alpha_rdata;
    logic [SYMB_WIDTH-1:0] log_rdata;

    assign accept   = bus.cfg_valid && cfg_ready_q;
    assign building = (state == BUILD);
    assign last     = (idx == LAST);
    assign rd_en    = bus.lk_valid && tbl_ready_q;
    assign next_cur = {cur[SYMB_WIDTH-2:0], 1'b0} ^ (cur[SYMB_WIDTH-1] ? poly : '0);

`ifdef GF_PRIM_CHECK_EN
    // An early return to 1 (or collapse to 0) means the element order is short of 2^m-1.
    assign abort = building && !last && (idx != '0) && ((cur == ONE) || (cur == '0));
`else
    assign abort = 1'b0;
`endif

    // The closing write fixes alpha^(2^m-1)=1 and the log(0)=0 convention.
    assign alpha_wdata = last ? ONE : cur;
    assign log_waddr   = last ? '0  : cur;
    assign log_wdata   = last ? '0  : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            poly        <= SYMB_WIDTH'(POLY);
            cur         <= ONE;
            idx         <= '0;
            cfg_ready_q <= 1'b1;
            tbl_ready_q <= 1'b0;
            done_q      <= 1'b0;
            prim_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                EMPTY, READY: begin
                    if (accept) begin
                        state       <= BUILD;
                        poly        <= bus.cfg_poly;
                        cur         <= ONE;
                        idx         <= '0;
                        cfg_ready_q <= 1'b0;
                        tbl_ready_q <= 1'b0;
                        prim_err_q  <= 1'b0;
                    end
                end
                BUILD: begin
                    if (abort) begin
                        state       <= EMPTY;
                        cfg_ready_q <= 1'b1;
                        prim_err_q  <= 1'b1;
                    end else if (last) begin
                        state       <= READY;
                        cfg_ready_q <= 1'b1;
                        tbl_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                    end else begin
                        cur <= next_cur;
                        idx <= idx + ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // The select travels with the read so lk_rdata holds steady between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_rvalid_q <= 1'b0;
            sel_q       <= LK_ALOG;
        end else begin
            lk_rvalid_q <= rd_en;
            if (rd_en)
                sel_q <= gf_lk_sel_e'(bus.lk_sel);
        end
    end

    gf_table_ram #(.WIDTH(SYMB_WIDTH), .DEPTH(DEPTH)) u_alpha_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (building),
        .waddr (idx),
        .wdata (alpha_wdata),
        .re    (rd_en),
        .raddr (bus.lk_addr),
        .rdata (alpha_rdata)
    );

    gf_table_ram #(.WIDTH(SYMB_WIDTH), .DEPTH(DEPTH)) u_log_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (building),
        .waddr (log_waddr),
        .wdata (log_wdata),
        .re    (rd_en),
        .raddr (bus.lk_addr),
        .rdata (log_rdata)
    );

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.tbl_ready = tbl_ready_q;
    assign bus.done      = done_q;
    assign bus.prim_err  = prim_err_q;
    assign bus.lk_rvalid = lk_rvalid_q;
    assign bus.lk_rdata  = (sel_q == LK_LOG) ? log_rdata : alpha_rdata;
endmodule

// File: tb/tb_gf_table_gen.sv
// tb/tb_gf_table_gen.sv - directed scoreboard bench for gf_table_gen (m=8 and m=4 instances)
module tb_gf_table_gen;
    import gf_pkg::*;

    localparam int DEPTH8 = SYMB_NUM;
    localparam int DEPTH4 = 16;

    logic clk;
    logic rst_n;

    gf_table_gen_if #(.SYMB_WIDTH(8)) bus8 ();
    gf_table_gen_if #(.SYMB_WIDTH(4)) bus4 ();

    gf_table_gen #(.SYMB_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    gf_table_gen #(.SYMB_WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int q8[$];
    int q4[$];
    int ref_alpha[DEPTH8];
    int ref_log[DEPTH8];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (q8.size() > 0 || bus8.lk_rvalid) begin
            chk("lk8_rvalid", int'(bus8.lk_rvalid), int'(q8.size() > 0));
            if (q8.size() > 0) begin
                int e;
                e = q8.pop_front();
                if (bus8.lk_rvalid) chk("lk8_rdata", int'(bus8.lk_rdata), e);
            end
        end
        if (q4.size() > 0 || bus4.lk_rvalid) begin
            chk("lk4_rvalid", int'(bus4.lk_rvalid), int'(q4.size() > 0));
            if (q4.size() > 0) begin
                int e;
                e = q4.pop_front();
                if (bus4.lk_rvalid) chk("lk4_rdata", int'(bus4.lk_rdata), e);
            end
        end
    endtask

    task automatic make_ref(input int poly);
        for (int i = 0; i < DEPTH8; i++) ref_log[i] = 0;
        for (int i = 0; i < DEPTH8 - 1; i++) begin
            ref_alpha[i] = int'(gf_alpha_pow(i, poly, 8));
            ref_log[ref_alpha[i]] = i;
        end
        ref_alpha[DEPTH8-1] = 1;
        ref_log[0] = 0;
        ref_log[1] = 0;
    endtask

    task automatic lk8(input logic sel, input int addr, input int exp);
        bus8.lk_valid = 1'b1;
        bus8.lk_sel   = sel;
        bus8.lk_addr  = 8'(addr);
        q8.push_back(exp);
        tick();
    endtask

    task automatic lk8_idle();
        bus8.lk_valid = 1'b0;
        tick();
    endtask

    task automatic build8(input int poly, input string tag);
        int done_at = -1;
        int rdy_hi  = 0;
        bus8.cfg_valid = 1'b1;
        bus8.cfg_poly  = 8'(poly);
        tick();
        bus8.cfg_valid = 1'b0;
        chk({tag, "_cfg_ready_t0"}, int'(bus8.cfg_ready), 0);
        chk({tag, "_tbl_ready_t0"}, int'(bus8.tbl_ready), 0);
        for (int k = 1; k <= DEPTH8 + 8 && done_at < 0; k++) begin
            tick();
            if (bus8.done) done_at = k;
            else if (bus8.cfg_ready) rdy_hi++;
        end
        chk({tag, "_done_edge"}, done_at, DEPTH8);
        chk({tag, "_cfg_ready_in_build"}, rdy_hi, 0);
        chk({tag, "_tbl_ready"}, int'(bus8.tbl_ready), 1);
        chk({tag, "_cfg_ready_end"}, int'(bus8.cfg_ready), 1);
        tick();
        chk({tag, "_done_one_cycle"}, int'(bus8.done), 0);
    endtask

    initial begin
        int end_at;
        int done_seen;
        int done4_at;

        rst_n          = 1'b0;
        bus8.cfg_valid = 1'b0; bus8.cfg_poly = '0; bus8.lk_valid = 1'b0; bus8.lk_sel = 1'b0; bus8.lk_addr = '0;
        bus4.cfg_valid = 1'b0; bus4.cfg_poly = '0; bus4.lk_valid = 1'b0; bus4.lk_sel = 1'b0; bus4.lk_addr = '0;
        repeat (3) tick();
        chk("rst_cfg_ready", int'(bus8.cfg_ready), 1);
        chk("rst_tbl_ready", int'(bus8.tbl_ready), 0);
        chk("rst_done",      int'(bus8.done), 0);
        chk("rst_prim_err",  int'(bus8.prim_err), 0);
        chk("rst_lk_rvalid", int'(bus8.lk_rvalid), 0);
        chk("rst_lk_rdata",  int'(bus8.lk_rdata), 0);
        rst_n = 1'b1;
        tick();

        // Lookup with no table is dropped.
        bus8.lk_valid = 1'b1; bus8.lk_addr = 8'h08;
        tick();
        bus8.lk_valid = 1'b0;
        chk("lk_when_empty", int'(bus8.lk_rvalid), 0);

        build8(32'h1D, "b1d");
        lk8(1'b0, 8,     32'h1D);
        lk8(1'b0, 255,   32'h01);
        lk8(1'b1, 32'h1D, 8);
        lk8(1'b1, 32'h02, 1);
        lk8(1'b1, 32'h01, 0);
        lk8(1'b1, 32'h00, 0);
        lk8_idle();

        make_ref(32'h1D);
        for (int a = 0; a < DEPTH8; a++) begin
            lk8(1'b0, a, ref_alpha[a]);
            lk8(1'b1, a, ref_log[a]);
        end
        lk8_idle();

        build8(32'h2B, "b2b");
        make_ref(32'h2B);
        lk8(1'b0, 8,   32'h2B);
        lk8(1'b0, 100, ref_alpha[100]);
        lk8(1'b1, ref_alpha[100], 100);
        lk8(1'b1, 32'h2B, 8);
        lk8_idle();

        // Non-primitive polynomial of order 51.
        bus8.cfg_valid = 1'b1; bus8.cfg_poly = 8'h1B;
        tick();
        bus8.cfg_valid = 1'b0;
        end_at = -1; done_seen = 0;
        for (int k = 1; k <= DEPTH8 + 8 && end_at < 0; k++) begin
            tick();
            if (bus8.done) done_seen++;
            if (bus8.cfg_ready) end_at = k;
        end
`ifdef GF_PRIM_CHECK_EN
        chk("prim_abort_edge", end_at, 52);
        chk("prim_err_set",    int'(bus8.prim_err), 1);
        chk("prim_tbl_ready",  int'(bus8.tbl_ready), 0);
        chk("prim_no_done",    done_seen, 0);
`else
        chk("noprim_end_edge", end_at, DEPTH8);
        chk("noprim_err_tied", int'(bus8.prim_err), 0);
        chk("noprim_tbl_ready", int'(bus8.tbl_ready), 1);
        chk("noprim_done",     done_seen, 1);
`endif
        tick();

        // Build interrupted by reset, with a lookup attempted mid-build.
        bus8.cfg_valid = 1'b1; bus8.cfg_poly = 8'h1D;
        tick();
        bus8.cfg_valid = 1'b0;
        chk("prim_err_cleared", int'(bus8.prim_err), 0);
        for (int k = 1; k < 10; k++) tick();
        bus8.lk_valid = 1'b1; bus8.lk_sel = 1'b0; bus8.lk_addr = 8'h08;
        tick();
        bus8.lk_valid = 1'b0;
        chk("lk_in_build", int'(bus8.lk_rvalid), 0);
        for (int k = 11; k < 100; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cfg_ready", int'(bus8.cfg_ready), 1);
        chk("mid_rst_tbl_ready", int'(bus8.tbl_ready), 0);
        chk("mid_rst_done",      int'(bus8.done), 0);
        chk("mid_rst_prim_err",  int'(bus8.prim_err), 0);
        chk("mid_rst_lk_rvalid", int'(bus8.lk_rvalid), 0);
        chk("mid_rst_lk_rdata",  int'(bus8.lk_rdata), 0);
        chk("mid_rst_state",     int'(dut8.state), int'(EMPTY));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        build8(32'h1D, "rebuild");
        make_ref(32'h1D);
        lk8(1'b0, 8,    32'h1D);
        lk8(1'b1, 32'h1D, 8);
        lk8(1'b0, 200,  ref_alpha[200]);
        lk8_idle();

        // m=4 instance, x^4+x+1.
        bus4.cfg_valid = 1'b1; bus4.cfg_poly = 4'h3;
        tick();
        bus4.cfg_valid = 1'b0;
        done4_at = -1;
        for (int k = 1; k <= DEPTH4 + 8 && done4_at < 0; k++) begin
            tick();
            if (bus4.done) done4_at = k;
        end
        chk("m4_done_edge", done4_at, DEPTH4);
        chk("m4_tbl_ready", int'(bus4.tbl_ready), 1);
        bus4.lk_valid = 1'b1; bus4.lk_sel = 1'b0; bus4.lk_addr = 4'h4; q4.push_back(32'h3);
        tick();
        bus4.lk_sel = 1'b1; bus4.lk_addr = 4'h9; q4.push_back(14);
        tick();
        bus4.lk_sel = 1'b0; bus4.lk_addr = 4'hF; q4.push_back(32'h1);
        tick();
        bus4.lk_valid = 1'b0;
        tick();
        chk("m4_q_drained", q4.size(), 0);
        chk("m8_q_drained", q8.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
